// File: rtl/sw_debounce_pkg.sv
// -----------------------------------------------------------------------------
// sw_debounce_pkg
// Shared definitions for the switch debouncer: the per-channel FSM state
// encoding and the default acceptance window (10 ms at a 50 MHz clock).
// -----------------------------------------------------------------------------
package sw_debounce_pkg;

    // Per-channel debounce state. WAIT_* states count stable cycles before
    // the new level is accepted.
    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        WAIT_HI = 2'd1,
        ST_HI   = 2'd2,
        WAIT_LO = 2'd3
    } db_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage : sw_debounce_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One switch channel: two-flop synchronizer, debounce FSM and stable-cycle
// counter. All outputs are registered.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   sw_raw    in   raw switch level, asynchronous to clk
//   sw_clean  out  debounced level
//   rise      out  one-cycle pulse when sw_clean goes 0->1
//   fall      out  one-cycle pulse when sw_clean goes 1->0
// -----------------------------------------------------------------------------
module debounce_channel
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_clean,
    output logic rise,
    output logic fall
);

    // Last count value before acceptance; the FSM leaves WAIT_* here, so the
    // counter can never wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    db_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            clean_q, clean_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    // Next-state, counter and output-pulse computation.
    always_comb begin
        s1_d    = sw_raw;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LO: begin
                clean_d = 1'b0;
                if (s2_q) begin
                    state_d = WAIT_HI;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_LO;
                end
            end
            WAIT_HI: begin
                if (!s2_q) begin
                    // Bounce: drop the pending rise without any pulse.
                    state_d = ST_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HI;
                    clean_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_HI: begin
                clean_d = 1'b1;
                if (!s2_q) begin
                    state_d = WAIT_LO;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_HI;
                end
            end
            WAIT_LO: begin
                if (s2_q) begin
                    state_d = ST_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LO;
                    clean_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = {CNT_W{1'b0}};
                clean_d = 1'b0;
            end
        endcase
    end

    // Synchronizer, FSM state, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= ST_LO;
            cnt_q   <= {CNT_W{1'b0}};
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sw_clean = clean_q;
    assign rise     = rise_q;
    assign fall     = fall_q;

endmodule : debounce_channel

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Conditions a bank of raw, bouncing switch inputs into clean synchronous
// levels plus single-cycle rise/fall pulses. Channels are independent.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   sw_raw    in   [N] raw switch levels, asynchronous to clk
//   sw_clean  out  [N] debounced levels
//   rise      out  [N] one-cycle pulse on each clean 0->1 transition
//   fall      out  [N] one-cycle pulse on each clean 1->0 transition
// -----------------------------------------------------------------------------
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int N               = 10,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sw_raw,
    output logic [N-1:0] sw_clean,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .sw_raw   (sw_raw[i]),
            .sw_clean (sw_clean[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce
// Directed self-checking bench for sw_debounce with DEBOUNCE_CYCLES=4, N=10.
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at the same point, so "edge e" below is the e-th rising edge after a drive.
// -----------------------------------------------------------------------------
module tb_sw_debounce;

    localparam int N = 10;
    localparam int DC = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] sw_raw;
    logic [N-1:0] sw_clean;
    logic [N-1:0] rise;
    logic [N-1:0] fall;

    int n_checks;
    int n_fails;

    sw_debounce #(
        .N               (N),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           ($clog2(DC))
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .sw_clean (sw_clean),
        .rise     (rise),
        .fall     (fall)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all three outputs against fixed expectations.
    task automatic chk_all(input string tag, input logic [N-1:0] c,
                           input logic [N-1:0] r, input logic [N-1:0] f);
        chk({tag, ".clean"}, 32'(sw_clean), 32'(c));
        chk({tag, ".rise"},  32'(rise),     32'(r));
        chk({tag, ".fall"},  32'(fall),     32'(f));
    endtask

    // Step n edges; the acceptance happens at edge acc (acc > n means never).
    task automatic window(input string tag, input int n, input int acc,
                          input logic [N-1:0] c_before, input logic [N-1:0] c_after,
                          input logic [N-1:0] r_exp, input logic [N-1:0] f_exp);
        for (int e = 1; e <= n; e++) begin
            tick();
            chk_all(tag,
                    (e >= acc) ? c_after : c_before,
                    (e == acc) ? r_exp : {N{1'b0}},
                    (e == acc) ? f_exp : {N{1'b0}});
        end
    endtask

    // Bound the whole run.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    // Directed stimulus.
    initial begin
        logic [4:0] bpat;
        logic [2:0] spat;
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b0;
        sw_raw   = 10'h3FF;

        // Reset held with all switches high: outputs stay zero.
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all("rst_hold", 10'h000, 10'h000, 10'h000);
        end

        // Release: all channels accept high at edge 7 with one rise pulse.
        reset = 1'b1;
        window("rst_rel", 9, 7, 10'h000, 10'h3FF, 10'h3FF, 10'h000);

        // All switches low: all channels fall at edge 7.
        sw_raw = 10'h000;
        window("all_lo", 9, 7, 10'h3FF, 10'h000, 10'h000, 10'h3FF);

        // Clean step on channel 0.
        sw_raw = 10'h001;
        window("step0", 9, 7, 10'h000, 10'h001, 10'h001, 10'h000);

        // Bounce rejection on channel 1: 1,0,1,1,0 then 0 held.
        bpat = 5'b01101;
        for (int k = 0; k < 5; k++) begin
            sw_raw[1] = bpat[k];
            tick();
            chk_all("bounce1", 10'h001, 10'h000, 10'h000);
        end
        sw_raw[1] = 1'b0;
        window("bounce1_hold", 10, 99, 10'h001, 10'h001, 10'h000, 10'h000);

        // Bounce then settle on channel 2: 1,0,1 then 1 held; rise at edge 9.
        spat = 3'b101;
        for (int k = 0; k < 3; k++) begin
            sw_raw[2] = spat[k];
            tick();
            chk_all("settle2", 10'h001, 10'h000, 10'h000);
        end
        window("settle2_hold", 8, 6, 10'h001, 10'h005, 10'h004, 10'h000);

        // Reset mid-wait on channel 3.
        sw_raw[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_all("rstmid_pre", 10'h005, 10'h000, 10'h000);
        end
        reset = 1'b0;
        #1;
        chk_all("rstmid_async", 10'h000, 10'h000, 10'h000);
        tick();
        tick();
        chk_all("rstmid_held", 10'h000, 10'h000, 10'h000);
        reset = 1'b1;
        window("rstmid_rel", 9, 7, 10'h000, 10'h00D, 10'h00D, 10'h000);

        // Settle channel 5 high, then rise ch4 and fall ch5 together.
        sw_raw[5] = 1'b1;
        window("ch5_hi", 8, 7, 10'h00D, 10'h02D, 10'h020, 10'h000);
        sw_raw[4] = 1'b1;
        sw_raw[5] = 1'b0;
        window("indep", 9, 7, 10'h02D, 10'h01D, 10'h010, 10'h020);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_sw_debounce

// File: doc/sw_debounce.md
# sw_debounce

Input-conditioning block for the board switch bank. It takes raw, asynchronous, bouncing `SW` levels and produces clean, synchronous levels plus single-cycle rise/fall pulses on the system clock. It sits between the `SW` pins and downstream logic such as flip-flop tops, so they never see metastable or bouncing inputs. The block produces the switch signals that those tops consume.

## Interface
- `N`, 10: number of switch channels.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range ≥ 2.
- `CNT_W`, $clog2(`DEBOUNCE_CYCLES`): counter width.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted at 0.
- `sw_raw`  in  N  raw switch levels, asynchronous to `clk`.
- `sw_clean`  out  N  debounced level per channel.
- `rise`  out  N  one-cycle pulse when `sw_clean[i]` goes 0→1.
- `fall`  out  N  one-cycle pulse when `sw_clean[i]` goes 1→0.

## Operation
- Channels are fully independent; the description below is for one channel `i`.
- Synchronizer: two flops, `s1` ← `sw_raw[i]`, `s2` ← `s1`. Only `s2` is used downstream.
- FSM states: `ST_LO`, `WAIT_HI`, `ST_HI`, `WAIT_LO`.
  - `ST_LO`: `sw_clean`=0. If `s2`=1, go to `WAIT_HI` and set `cnt`=0.
  - `WAIT_HI`:
    - If `s2`=0 (bounce), return to `ST_LO`; `cnt` is don't-care and no pulse is issued.
    - Else if `cnt`==`DEBOUNCE_CYCLES`-1, go to `ST_HI`, set `sw_clean`=1, pulse `rise`.
    - Else `cnt`++.
  - `ST_HI` and `WAIT_LO` mirror `ST_LO` and `WAIT_HI` with polarity inverted; `fall` is pulsed on acceptance.
- `cnt` never wraps: it saturates by construction, because the FSM leaves `WAIT_*` at `DEBOUNCE_CYCLES`-1.
- Each pulse is exactly one cycle wide. `rise` and `fall` are never both high on the same channel in the same cycle.
- Any bounce shorter than `DEBOUNCE_CYCLES` cycles, measured at `s2`, is rejected entirely: no change on `sw_clean` and no pulse.

Reset (`reset`=0, asynchronous):
- Values: `s1`=`s2`=0, state=`ST_LO`, `cnt`=0, `sw_clean`=0, `rise`=`fall`=0.
- If reset is asserted mid-`WAIT_*`, the pending transition is discarded.
- After release with a switch held high, the channel debounces from `ST_LO`. It then asserts `sw_clean` and issues one `rise` pulse, with the same latency as any other transition.

## Timing
- All outputs are registered, so there is no combinational path from `sw_raw`.
- Latency: suppose `sw_raw` changes and remains stable, and it meets setup before edge E1. Then:
  - `s2` updates at edge E2.
  - The FSM enters `WAIT_*` at E3.
  - `sw_clean` and the pulse update at edge E(`DEBOUNCE_CYCLES`+3).
  - The pulse deasserts at the following edge.
- A glitch at `s2` shorter than 1 cycle cannot occur, because `s2` is registered.
- A raw pulse narrower than one clock period may be missed entirely; this is acceptable.
- Simultaneous events on different channels are processed in parallel with no interaction.

## Structure
- Package `sw_debounce_pkg` contains:
  - `typedef enum logic [1:0] {ST_LO, WAIT_HI, ST_HI, WAIT_LO} db_state_t`
  - `localparam DEBOUNCE_CYCLES_DEFAULT = 500000`
- Sub-module `debounce_channel`: one synchronizer, FSM and counter, parameterised on `DEBOUNCE_CYCLES`/`CNT_W`, with a 1-bit interface.
- `sw_debounce` instantiates `N` copies of `debounce_channel` in a generate loop.
- The board-level top connects `SW` to `sw_raw` and feeds `sw_clean`/`rise` to consumer blocks.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and N=10.
- Reset: drive `reset`=0 with `sw_raw`=10'h3FF → all outputs are 0 while reset is held. After release, `sw_clean`=10'h3FF at edge 7 after release, and `rise`=10'h3FF for exactly one cycle.
- Clean step: `sw_raw[0]` goes 0→1 before E1 and stays → `sw_clean[0]`=1 after E7; `rise[0]` is high only between E7 and E8; `fall`=0 throughout.
- Bounce rejection: `sw_raw[1]` pattern 1,0,1,1,0 at one cycle each, then 0 held → `sw_clean[1]` stays 0 and no `rise[1]`/`fall[1]` pulses occur.
- Bounce then settle: `sw_raw[2]` pattern 1,0,1 then 1 held → exactly one `rise[2]`, 7 edges after the final 0→1, and `sw_clean[2]`=1.
- Reset mid-wait: `sw_raw[3]`=1 held; assert `reset` after E5, release 2 cycles later → no pulse before reset. A full 7-edge debounce restarts after release, followed by one `rise[3]`.
- Independence: `sw_raw[4]` rises and `sw_raw[5]` falls (from a settled high) on the same cycle → `rise[4]` and `fall[5]` pulse on the same edge; all other channels are unchanged.
